// File: rtl/fp8_mac_pkg.sv
// Shared types and constants for the FP8 (E4M3, bias 7) MAC sequencer.
package fp8_mac_pkg;

  typedef logic [7:0] fp8_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_ISSUE,
    S_MUL_WAIT,
    S_ADD_ISSUE,
    S_ADD_WAIT,
    S_OUTPUT
  } seq_state_t;

  localparam fp8_t        FP8_ZERO = 8'h00;
  localparam int unsigned FP8_BIAS = 7;

endpackage

// File: rtl/fp8_mac_sequencer_if.sv
// Operand, arithmetic-unit and result streams of the FP8 MAC sequencer.
// master = sequencer side, slave = operand source / arithmetic units / consumer.
interface fp8_mac_sequencer_if;
  import fp8_mac_pkg::*;

  logic in_valid;
  logic in_ready;
  fp8_t in_a;
  fp8_t in_b;

  logic mul_start;
  fp8_t mul_a;
  fp8_t mul_b;
  logic mul_done;
  fp8_t mul_product;

  logic add_start;
  fp8_t add_a;
  fp8_t add_b;
  logic add_done;
  fp8_t add_sum;

  logic out_valid;
  logic out_ready;
  fp8_t out_result;

  modport master (
    input  in_valid, in_a, in_b, mul_done, mul_product, add_done, add_sum, out_ready,
    output in_ready, mul_start, mul_a, mul_b, add_start, add_a, add_b, out_valid, out_result
  );

  modport slave (
    output in_valid, in_a, in_b, mul_done, mul_product, add_done, add_sum, out_ready,
    input  in_ready, mul_start, mul_a, mul_b, add_start, add_a, add_b, out_valid, out_result
  );

endinterface

// File: rtl/fp8_wait_watchdog.sv
// Wait-state timeout counter; counts cycles while wait_i is high and flags
// timeout_o on the WDOG_CYCLES-th cycle without a matching done.
module fp8_wait_watchdog #(
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wait_i,
  input  logic done_i,
  output logic timeout_o
);

  localparam int unsigned CW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WDOG_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wait states are only ever entered from an issue state, so clearing
  // whenever wait_i is low restarts the count on every wait-state entry.
  always_comb begin
    cnt_d = cnt_q;
    if (!wait_i || done_i || timeout_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = wait_i && !done_i && (cnt_q == LAST);

endmodule

// File: rtl/fp8_mac_sequencer.sv
// Sequences one shared FP8 multiplier and adder to form a VEC_LEN-pair dot product.
// Optional wait-state watchdog enabled by defining FP8_MAC_WATCHDOG_EN.
module fp8_mac_sequencer
  import fp8_mac_pkg::*;
#(
  parameter int unsigned VEC_LEN     = 4,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  fp8_mac_sequencer_if.master bus,
  output logic                busy,
  output logic                err
);

  if (VEC_LEN < 1 || VEC_LEN > 255 || WDOG_CYCLES < 1) begin : g_param_check
    $error("fp8_mac_sequencer: VEC_LEN must be 1..255 and WDOG_CYCLES >= 1");
  end

  localparam logic [7:0] LAST_IDX = 8'(VEC_LEN - 1);

  seq_state_t state_q, state_d;
  fp8_t       acc_q, acc_d;
  fp8_t       mul_a_q, mul_a_d;
  fp8_t       mul_b_q, mul_b_d;
  fp8_t       add_b_q, add_b_d;
  logic [7:0] elem_cnt_q, elem_cnt_d;
  logic       in_ready_q;
  logic       wdog_timeout;

`ifdef FP8_MAC_WATCHDOG_EN
  logic in_wait;
  logic wait_done;
  logic err_q;

  assign in_wait   = (state_q == S_MUL_WAIT) || (state_q == S_ADD_WAIT);
  assign wait_done = ((state_q == S_MUL_WAIT) && bus.mul_done) ||
                     ((state_q == S_ADD_WAIT) && bus.add_done);

  fp8_wait_watchdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk_i    (clk),
    .rst_i    (rst),
    .wait_i   (in_wait),
    .done_i   (wait_done),
    .timeout_o(wdog_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (wdog_timeout) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign wdog_timeout = 1'b0;
  assign err          = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    add_b_d    = add_b_q;
    elem_cnt_d = elem_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          mul_a_d = bus.in_a;
          mul_b_d = bus.in_b;
          state_d = S_MUL_ISSUE;
        end
      end
      S_MUL_ISSUE: state_d = S_MUL_WAIT;
      S_MUL_WAIT: begin
        if (bus.mul_done) begin
          add_b_d = bus.mul_product;
          state_d = S_ADD_ISSUE;
        end else if (wdog_timeout) begin
          acc_d      = FP8_ZERO;
          elem_cnt_d = '0;
          state_d    = S_IDLE;
        end
      end
      S_ADD_ISSUE: state_d = S_ADD_WAIT;
      S_ADD_WAIT: begin
        if (bus.add_done) begin
          acc_d = bus.add_sum;
          if (elem_cnt_q == LAST_IDX) begin
            elem_cnt_d = '0;
            state_d    = S_OUTPUT;
          end else begin
            elem_cnt_d = elem_cnt_q + 8'd1;
            state_d    = S_IDLE;
          end
        end else if (wdog_timeout) begin
          acc_d      = FP8_ZERO;
          elem_cnt_d = '0;
          state_d    = S_IDLE;
        end
      end
      S_OUTPUT: begin
        if (bus.out_ready) begin
          acc_d   = FP8_ZERO;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // in_ready is registered from the next state so it reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= FP8_ZERO;
      mul_a_q    <= FP8_ZERO;
      mul_b_q    <= FP8_ZERO;
      add_b_q    <= FP8_ZERO;
      elem_cnt_q <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      add_b_q    <= add_b_d;
      elem_cnt_q <= elem_cnt_d;
      in_ready_q <= (state_d == S_IDLE);
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mul_start  = (state_q == S_MUL_ISSUE);
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.add_start  = (state_q == S_ADD_ISSUE);
  assign bus.add_a      = acc_q;
  assign bus.add_b      = add_b_q;
  assign bus.out_valid  = (state_q == S_OUTPUT);
  assign bus.out_result = acc_q;
  assign busy           = (state_q != S_IDLE);

endmodule
